step_dir_receiver: RTL and testbench

STEP_DIR_RECEIVER -- requirements
Module: step_dir_receiver

---
 rtl/stepper_pkg.sv | 24 ++
 rtl/step_input_filter.sv | 64 ++++++
 rtl/step_dir_receiver.sv | 158 +++++++++++++++
 tb/tb_step_dir_receiver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared constants for the step/dir receiver: register map, CONTROL/STATUS
// bit positions and the coil phase table.
package stepper_pkg;

  localparam logic [3:0] ADDR_POSITION  = 4'h0;
  localparam logic [3:0] ADDR_CONTROL   = 4'h1;
  localparam logic [3:0] ADDR_MIN_PULSE = 4'h2;
  localparam logic [3:0] ADDR_STATUS    = 4'h3;
  localparam logic [3:0] ADDR_PERIOD    = 4'h4;

  localparam int CTRL_HALF   = 0;
  localparam int CTRL_INVERT = 1;
  localparam int CTRL_HOLD   = 2;

  localparam int STAT_DIR_SETUP = 0;
  localparam int STAT_MISSED    = 2;

  // Coil drive {B-, A-, B+, A+}; element [0] sits in the low nibble.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

endpackage

// File: rtl/step_input_filter.sv
// Two-flop synchronizer plus a stability filter for one asynchronous input.
// The filtered level follows the input only after it has differed for min_pulse_i cycles.
module step_input_filter (
  input  logic       clk,
  input  logic       reset,
  input  logic       async_i,
  input  logic [7:0] min_pulse_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       toggle_o
);

  logic       meta_q, sync_q;
  logic       level_q, level_d;
  logic       prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] prime_q;
  logic       armed_q;
  logic [7:0] min_eff;

  assign min_eff = (min_pulse_i == 8'd0) ? 8'd1 : min_pulse_i;

  always_comb begin
    level_d = level_q;
    cnt_d   = 8'd0;
    if (sync_q != level_q) begin
      if ({1'b0, cnt_q} + 9'd1 >= {1'b0, min_eff}) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Rising edges are only reported once a genuine low has been seen after
  // reset, so an input already high at release cannot fake an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= 8'd0;
      prime_q <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
      if (prime_q != 2'd2) begin
        prime_q <= prime_q + 2'd1;
      end else if (!sync_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign level_o  = level_q;
  assign rise_o   = level_q & ~prev_q & armed_q;
  assign toggle_o = level_q ^ prev_q;

endmodule

// File: rtl/step_dir_receiver.sv
// Step/direction receiver: filters step, dir and enable, tracks position and
// coil phase, and exposes POSITION/CONTROL/MIN_PULSE/STATUS/PERIOD over Avalon-MM.
module step_dir_receiver
  import stepper_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ    = 50_000_000,
  parameter int FILTER_CYCLES    = 4,
  parameter int DIR_SETUP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        step,
  input  logic        dir,
  input  logic        enable,
  output logic [3:0]  phase,
  output logic        fault
);

  localparam int unsigned unused_clock_hz = CLOCK_FREQ_HZ;
  localparam logic [15:0] DIR_SETUP = 16'(DIR_SETUP_CYCLES);
  localparam logic [7:0]  MIN_RESET = 8'(FILTER_CYCLES);

  logic step_lvl, step_rise, step_tog;
  logic dir_lvl, dir_rise, dir_chg;
  logic en_lvl, en_rise, en_tog;
  logic unused_filter_outs;

  logic [31:0] pos_q, pos_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  minp_q, minp_d;
  logic [2:0]  status_q, status_d;
  logic [31:0] period_q, period_d;
  logic [31:0] since_q, since_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] dir_age_q, dir_age_d;
  logic [3:0]  phase_q, phase_d;
  logic        fault_q;
  logic [31:0] rdata_q, rdata_d;

  logic        step_evt, take_step, fwd;
  logic        wr_pos, wr_ctrl, wr_minp, wr_status;
  logic [2:0]  idx_base, idx_inc, status_set, status_clr;

  step_input_filter u_step_filt (
    .clk(clk), .reset(reset), .async_i(step), .min_pulse_i(minp_q),
    .level_o(step_lvl), .rise_o(step_rise), .toggle_o(step_tog)
  );
  step_input_filter u_dir_filt (
    .clk(clk), .reset(reset), .async_i(dir), .min_pulse_i(minp_q),
    .level_o(dir_lvl), .rise_o(dir_rise), .toggle_o(dir_chg)
  );
  step_input_filter u_en_filt (
    .clk(clk), .reset(reset), .async_i(enable), .min_pulse_i(minp_q),
    .level_o(en_lvl), .rise_o(en_rise), .toggle_o(en_tog)
  );

  assign unused_filter_outs = step_lvl ^ step_tog ^ dir_rise ^ en_rise ^ en_tog;

  always_comb begin
    step_evt  = step_rise;
    take_step = step_evt & en_lvl;
    fwd       = ~(dir_lvl ^ ctrl_q[CTRL_INVERT]);
    wr_pos    = write && (address == ADDR_POSITION);
    wr_ctrl   = write && (address == ADDR_CONTROL);
    wr_minp   = write && (address == ADDR_MIN_PULSE);
    wr_status = write && (address == ADDR_STATUS);

    // A concurrent POSITION write overrides the step; the phase still moves.
    pos_d = pos_q;
    if (wr_pos) begin
      pos_d = writedata;
    end else if (take_step) begin
      pos_d = fwd ? pos_q + 32'd1 : pos_q - 32'd1;
    end

    ctrl_d = wr_ctrl ? writedata[2:0] : ctrl_q;
    minp_d = wr_minp ? writedata[7:0] : minp_q;

    idx_base = (wr_ctrl && !writedata[CTRL_HALF]) ? {idx_q[2:1], 1'b0} : idx_q;
    idx_inc  = ctrl_q[CTRL_HALF] ? 3'd1 : 3'd2;
    idx_d    = idx_base;
    if (take_step) begin
      idx_d = fwd ? idx_base + idx_inc : idx_base - idx_inc;
    end

    dir_age_d = dir_age_q;
    if (dir_chg) begin
      dir_age_d = 16'd0;
    end else if (dir_age_q < DIR_SETUP) begin
      dir_age_d = dir_age_q + 16'd1;
    end

    status_set = 3'b000;
    status_set[STAT_DIR_SETUP] = step_evt && (dir_chg || (dir_age_q < DIR_SETUP));
    status_set[STAT_MISSED]    = step_evt && !en_lvl;
    status_clr = wr_status ? writedata[2:0] : 3'b000;
    status_d   = (status_q & ~status_clr) | status_set;

    since_d  = (since_q == 32'hFFFF_FFFF) ? since_q : since_q + 32'd1;
    period_d = period_q;
    if (step_evt) begin
      period_d = since_q;
      since_d  = 32'd1;
    end

    phase_d = (en_lvl || ctrl_d[CTRL_HOLD]) ? PHASE_TABLE[idx_d] : 4'b0000;

    rdata_d = rdata_q;
    if (read) begin
      case (address)
        ADDR_POSITION:  rdata_d = pos_q;
        ADDR_CONTROL:   rdata_d = {29'd0, ctrl_q};
        ADDR_MIN_PULSE: rdata_d = {24'd0, minp_q};
        ADDR_STATUS:    rdata_d = {29'd0, status_q};
        ADDR_PERIOD:    rdata_d = period_q;
        default:        rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q     <= 32'd0;
      ctrl_q    <= 3'd0;
      minp_q    <= MIN_RESET;
      status_q  <= 3'd0;
      period_q  <= 32'hFFFF_FFFF;
      since_q   <= 32'hFFFF_FFFF;
      idx_q     <= 3'd0;
      dir_age_q <= DIR_SETUP;
      phase_q   <= 4'b0000;
      fault_q   <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      pos_q     <= pos_d;
      ctrl_q    <= ctrl_d;
      minp_q    <= minp_d;
      status_q  <= status_d;
      period_q  <= period_d;
      since_q   <= since_d;
      idx_q     <= idx_d;
      dir_age_q <= dir_age_d;
      phase_q   <= phase_d;
      fault_q   <= |status_q;
      rdata_q   <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign phase    = phase_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_step_dir_receiver.sv
// Directed bench for step_dir_receiver: bus tasks, step pulse driver and a
// single checking task feeding the final error/check count.
module tb_step_dir_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [3:0]  address = 4'h0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        step = 1'b0;
  logic        dir = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  phase;
  logic        fault;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] rd;

  step_dir_receiver dut (
    .clk(clk), .reset(reset), .write(write), .read(read), .address(address),
    .writedata(writedata), .readdata(readdata), .step(step), .dir(dir),
    .enable(enable), .phase(phase), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    write = 1'b0; address = 4'h0; writedata = 32'd0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    read = 1'b1; address = a;
    @(negedge clk);
    read = 1'b0; address = 4'h0;
    d = readdata;
  endtask

  // Starts at a negedge; rise-to-rise spacing of back-to-back calls is hi+lo.
  task automatic step_pulse(input int hi, input int lo);
    step = 1'b1;
    repeat (hi) @(negedge clk);
    step = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);

    check("reset_phase", {28'd0, phase}, 32'h0);
    check("reset_fault", {31'd0, fault}, 32'h0);
    check("reset_readdata", readdata, 32'h0);
    bus_rd(4'h0, rd); check("reset_position", rd, 32'h0);
    bus_rd(4'h1, rd); check("reset_control", rd, 32'h0);
    bus_rd(4'h2, rd); check("reset_min_pulse", rd, 32'd4);
    bus_rd(4'h3, rd); check("reset_status", rd, 32'h0);
    bus_rd(4'h4, rd); check("reset_period", rd, 32'hFFFF_FFFF);
    bus_rd(4'h7, rd); check("unmapped_read", rd, 32'h0);

    // Half-step, forward, ten clean pulses.
    enable = 1'b1;
    bus_wr(4'h1, 32'h1);
    tick(10);
    check("enabled_phase_idx0", {28'd0, phase}, 32'b0001);
    for (int i = 0; i < 10; i++) step_pulse(8, 8);
    tick(10);
    bus_rd(4'h0, rd); check("ten_steps_position", rd, 32'd10);
    check("ten_steps_phase", {28'd0, phase}, 32'b0010);
    bus_rd(4'h3, rd); check("ten_steps_status", rd, 32'h0);

    // Two-cycle glitch is rejected by a four-cycle filter.
    step_pulse(2, 20);
    bus_rd(4'h0, rd); check("glitch_position", rd, 32'd10);

    // MIN_PULSE=0 behaves as one cycle, so the same glitch now counts.
    bus_wr(4'h2, 32'h0);
    bus_rd(4'h2, rd); check("min_pulse_zero_rb", rd, 32'h0);
    step_pulse(2, 10);
    bus_rd(4'h0, rd); check("min_pulse_zero_step", rd, 32'd11);
    check("min_pulse_zero_phase", {28'd0, phase}, 32'b0110);
    bus_wr(4'h2, 32'd4);
    bus_wr(4'h7, 32'h1234);

    // Position wrap both directions.
    bus_wr(4'h0, 32'hFFFF_FFFF);
    step_pulse(8, 12);
    bus_rd(4'h0, rd); check("wrap_forward", rd, 32'h0);
    bus_wr(4'h0, 32'h8000_0000);
    dir = 1'b1;
    tick(20);
    step_pulse(8, 12);
    bus_rd(4'h0, rd); check("wrap_reverse", rd, 32'h7FFF_FFFF);
    dir = 1'b0;
    tick(20);
    bus_rd(4'h3, rd); check("wrap_status_clean", rd, 32'h0);

    // Direction change three cycles before the step.
    dir = 1'b1;
    tick(3);
    step_pulse(8, 20);
    bus_rd(4'h3, rd); check("dir_setup_status", rd, 32'h1);
    check("dir_setup_fault", {31'd0, fault}, 32'h1);
    bus_rd(4'h0, rd); check("dir_setup_position", rd, 32'h7FFF_FFFE);
    bus_wr(4'h3, 32'h1);
    tick(2);
    bus_rd(4'h3, rd); check("dir_setup_cleared", rd, 32'h0);
    check("fault_cleared", {31'd0, fault}, 32'h0);
    dir = 1'b0;
    tick(20);

    // Disabled step: no motion, coils off, missed-step flag.
    enable = 1'b0;
    tick(20);
    step_pulse(8, 20);
    check("disabled_phase_off", {28'd0, phase}, 32'h0);
    bus_rd(4'h0, rd); check("disabled_position", rd, 32'h7FFF_FFFE);
    bus_rd(4'h3, rd); check("missed_step_status", rd, 32'h4);
    check("missed_step_fault", {31'd0, fault}, 32'h1);
    bus_wr(4'h1, 32'h5);
    tick(2);
    check("hold_phase", {28'd0, phase}, 32'b0010);
    bus_wr(4'h3, 32'h4);
    enable = 1'b1;
    tick(20);

    // Step to odd index, then switch to full-step mode.
    step_pulse(8, 12);
    check("half_idx3_phase", {28'd0, phase}, 32'b0110);
    bus_wr(4'h1, 32'h0);
    tick(1);
    check("full_round_down_phase", {28'd0, phase}, 32'b0010);
    step_pulse(8, 92);
    check("full_step_phase", {28'd0, phase}, 32'b0100);
    step_pulse(8, 92);
    check("full_step2_phase", {28'd0, phase}, 32'b1000);
    bus_rd(4'h4, rd); check("period_100", rd, 32'd100);
    tick(3);
    check("readdata_hold", readdata, 32'd100);
    bus_rd(4'h0, rd); check("full_step_position", rd, 32'h8000_0001);

    // Reset while a step pulse is pending and still high at release.
    step = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(30);
    bus_rd(4'h0, rd); check("reset_mid_pulse_pos", rd, 32'h0);
    step = 1'b0;
    tick(20);
    bus_rd(4'h0, rd); check("no_event_on_fall", rd, 32'h0);
    step_pulse(8, 20);
    bus_rd(4'h0, rd); check("step_after_rearm", rd, 32'h1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
